// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit for addi/bne/lw.
// Sequences DECODE/EXEC/MEM/WB and drives datapath controls.
module multicycle_ctrl_fsm #(
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic                  eq_i,
   input  logic                  mem_ack_i,
   output logic [4:0]            rs1_o,
   output logic [4:0]            rs2_o,
   output logic [4:0]            rd_o,
   output logic [2:0]            alu_ctrl_o,
   output logic [2:0]            imm_src_o,
   output logic                  alu_src_o,
   output logic                  mem_read_o,
   output logic                  reg_write_o,
   output logic                  pc_en_o,
   output logic                  pc_src_o,
   output logic                  illegal_o,
   output logic                  mem_err_o,
   output logic [CNT_WIDTH-1:0]  retired_o
);

   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_BNE  = 7'b1100011;
   localparam logic [6:0] OP_LW   = 7'b0000011;

   localparam logic [2:0] ALU_SUM = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_B = 3'd3;

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_e;

   state_e               state_q, state_d;
   logic [6:0]           op_q, op_d;
   logic [2:0]           f3_q, f3_d;
   logic [4:0]           rd_q, rd_d;
   logic [4:0]           rs1_q, rs1_d;
   logic [4:0]           rs2_q, rs2_d;
   logic [TW-1:0]        cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic                 live_q, live_d;

   logic unused_hi;
   assign unused_hi = ^instr_i[DATA_WIDTH-1:25];

   logic is_addi, is_bne, is_lw, is_legal;
   assign is_addi  = (op_q == OP_ADDI) && (f3_q == 3'b000);
   assign is_bne   = (op_q == OP_BNE)  && (f3_q == 3'b001);
   assign is_lw    = (op_q == OP_LW)   && (f3_q == 3'b010);
   assign is_legal = is_addi | is_bne | is_lw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         cnt_q     <= '0;
         retired_q <= '0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         cnt_q     <= cnt_d;
         retired_q <= retired_d;
         live_q    <= live_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      f3_d          = f3_q;
      rd_d          = rd_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      cnt_d         = cnt_q;
      retired_d     = retired_q;
      live_d        = 1'b1;
      instr_ready_o = 1'b0;
      alu_ctrl_o    = ALU_SUM;
      imm_src_o     = IMM_I;
      alu_src_o     = 1'b0;
      mem_read_o    = 1'b0;
      reg_write_o   = 1'b0;
      pc_en_o       = 1'b0;
      pc_src_o      = 1'b0;
      illegal_o     = 1'b0;
      mem_err_o     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // ready stays low until the first edge after reset release
            instr_ready_o = live_q;
            if (live_q && instr_valid_i) begin
               op_d    = instr_i[6:0];
               rd_d    = instr_i[11:7];
               f3_d    = instr_i[14:12];
               rs1_d   = instr_i[19:15];
               rs2_d   = instr_i[24:20];
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            imm_src_o = is_bne ? IMM_B : IMM_I;
            if (!is_legal) begin
               illegal_o = 1'b1;
               pc_en_o   = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            unique case (1'b1)
               is_bne: begin
                  alu_ctrl_o = ALU_SUB;
                  imm_src_o  = IMM_B;
                  pc_en_o    = 1'b1;
                  pc_src_o   = ~eq_i;
                  retired_d  = retired_q + CNT_WIDTH'(1);
                  state_d    = S_IDLE;
               end
               is_lw: begin
                  alu_src_o = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_MEM;
               end
               default: begin
                  alu_src_o = 1'b1;
                  state_d   = S_WB;
               end
            endcase
         end

         S_MEM: begin
            mem_read_o = 1'b1;
            cnt_d      = cnt_q + TW'(1);
            // an ack on the last allowed cycle still completes the load
            if (mem_ack_i) begin
               state_d = S_WB;
            end else if (cnt_q == T_LAST) begin
               mem_err_o = 1'b1;
               pc_en_o   = 1'b1;
               state_d   = S_IDLE;
            end
         end

         S_WB: begin
            reg_write_o = (rd_q != 5'd0);
            pc_en_o     = 1'b1;
            retired_d   = retired_q + CNT_WIDTH'(1);
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign rs1_o     = rs1_q;
   assign rs2_o     = rs2_q;
   assign rd_o      = rd_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm against a timeline model.
module tb_multicycle_ctrl_fsm;
   localparam int CW = 4;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   instr_i = '0;
   logic          instr_valid_i = 1'b0;
   logic          instr_ready_o;
   logic          eq_i = 1'b0;
   logic          mem_ack_i = 1'b0;
   logic [4:0]    rs1_o, rs2_o, rd_o;
   logic [2:0]    alu_ctrl_o, imm_src_o;
   logic          alu_src_o, mem_read_o, reg_write_o;
   logic          pc_en_o, pc_src_o, illegal_o, mem_err_o;
   logic [CW-1:0] retired_o;

   multicycle_ctrl_fsm #(
      .DATA_WIDTH (32),
      .MEM_TIMEOUT(TMO),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_i      (instr_i),
      .instr_valid_i(instr_valid_i),
      .instr_ready_o(instr_ready_o),
      .eq_i         (eq_i),
      .mem_ack_i    (mem_ack_i),
      .rs1_o        (rs1_o),
      .rs2_o        (rs2_o),
      .rd_o         (rd_o),
      .alu_ctrl_o   (alu_ctrl_o),
      .imm_src_o    (imm_src_o),
      .alu_src_o    (alu_src_o),
      .mem_read_o   (mem_read_o),
      .reg_write_o  (reg_write_o),
      .pc_en_o      (pc_en_o),
      .pc_src_o     (pc_src_o),
      .illegal_o    (illegal_o),
      .mem_err_o    (mem_err_o),
      .retired_o    (retired_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int unsigned model_ret = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected behaviour as a timeline: cycle c after the handshake.
   task automatic run_instr(input logic [31:0] ins, input logic eq,
                            input int nwait, input bit noack);
      logic [6:0] op;
      logic [2:0] f3;
      bit a, b, l, ill, tmo, wr;
      int last, mem_end;
      string t;
      op   = ins[6:0];
      f3   = ins[14:12];
      a    = (op == 7'h13) && (f3 == 3'd0);
      b    = (op == 7'h63) && (f3 == 3'd1);
      l    = (op == 7'h03) && (f3 == 3'd2);
      ill  = !(a || b || l);
      tmo  = l && noack;
      last = ill ? 1 : b ? 2 : a ? 3 : tmo ? 2 + TMO : 4 + nwait;
      mem_end = tmo ? last : last - 1;
      wr   = (a || l) && !tmo && (ins[11:7] != 5'd0);

      instr_i       = ins;
      instr_valid_i = 1'b1;
      eq_i          = 1'b0;
      mem_ack_i     = 1'b0;
      #1;
      chk($sformatf("ready_hs %h", ins), 32'(instr_ready_o), 32'd1);
      @(posedge clk);
      #1;
      for (int c = 1; c <= last; c++) begin
         instr_valid_i = 1'($urandom);
         instr_i       = $urandom;
         eq_i          = (c == 2) ? eq : 1'($urandom);
         if (c < 3) mem_ack_i = 1'($urandom);
         else mem_ack_i = l && !noack && (c == 3 + nwait);
         #1;
         t = $sformatf("%h c%0d", ins, c);
         chk({"ready ", t}, 32'(instr_ready_o), 32'd0);
         chk({"illegal ", t}, 32'(illegal_o), 32'(ill && c == 1));
         chk({"pc_en ", t}, 32'(pc_en_o), 32'(c == last));
         chk({"pc_src ", t}, 32'(pc_src_o), 32'(b && c == last && !eq));
         chk({"mem_read ", t}, 32'(mem_read_o),
             32'(l && c >= 3 && c <= mem_end));
         chk({"mem_err ", t}, 32'(mem_err_o), 32'(tmo && c == last));
         chk({"reg_write ", t}, 32'(reg_write_o), 32'(wr && c == last));
         if (c == 1) begin
            chk({"rd ", t}, 32'(rd_o), 32'(ins[11:7]));
            chk({"rs1 ", t}, 32'(rs1_o), 32'(ins[19:15]));
            chk({"rs2 ", t}, 32'(rs2_o), 32'(ins[24:20]));
            if (!ill) chk({"imm_d ", t}, 32'(imm_src_o), b ? 32'd3 : 32'd0);
         end
         if (c == 2) begin
            chk({"alu_ctrl ", t}, 32'(alu_ctrl_o), b ? 32'd1 : 32'd0);
            chk({"alu_src ", t}, 32'(alu_src_o), 32'(!b));
            chk({"imm_e ", t}, 32'(imm_src_o), b ? 32'd3 : 32'd0);
         end
         @(posedge clk);
         #1;
      end
      instr_valid_i = 1'b0;
      mem_ack_i     = 1'b0;
      if (!ill && !tmo) model_ret = (model_ret + 1) % (1 << CW);
      #1;
      chk($sformatf("ready_end %h", ins), 32'(instr_ready_o), 32'd1);
      chk($sformatf("retired %h", ins), 32'(retired_o), model_ret);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         0: r[14:0] = {3'd0, r[11:7], 7'h13};
         1: r[14:0] = {3'd1, r[11:7], 7'h63};
         2: r[14:0] = {3'd2, r[11:7], 7'h03};
         3: r[14:0] = {3'($urandom_range(1, 7)), r[11:7], 7'h13};
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      step();
      step();
      chk("rst ready", 32'(instr_ready_o), 32'd0);
      chk("rst retired", 32'(retired_o), 32'd0);
      chk("rst pc_en", 32'(pc_en_o), 32'd0);
      chk("rst reg_write", 32'(reg_write_o), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("ready before edge", 32'(instr_ready_o), 32'd0);
      step();
      chk("ready after edge", 32'(instr_ready_o), 32'd1);

      run_instr(32'h0070_0293, 1'b0, 0, 1'b0);
      run_instr(32'h0020_9463, 1'b0, 0, 1'b0);
      run_instr(32'h0020_9463, 1'b1, 0, 1'b0);
      run_instr(32'h0000_A303, 1'b0, 2, 1'b0);
      run_instr(32'h0000_A303, 1'b0, 0, 1'b0);
      run_instr(32'h0000_A303, 1'b0, 0, 1'b1);
      run_instr(32'h0000_A303, 1'b0, TMO - 1, 1'b0);
      run_instr(32'h0000_0033, 1'b0, 0, 1'b0);
      run_instr(32'h0010_1293, 1'b0, 0, 1'b0);
      run_instr(32'h0070_0013, 1'b0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_instr(rand_instr(), 1'($urandom), $urandom_range(0, TMO - 1),
                   ($urandom_range(0, 5) == 0));
      end

      while (model_ret != (1 << CW) - 1) run_instr(32'h0070_0293, 1'b0, 0, 1'b0);
      run_instr(32'h0070_0293, 1'b0, 0, 1'b0);
      chk("wrap to zero", 32'(retired_o), 32'd0);

      instr_i       = 32'h0000_A303;
      instr_valid_i = 1'b1;
      step();
      instr_valid_i = 1'b0;
      step();
      step();
      step();
      chk("mid mem_read", 32'(mem_read_o), 32'd1);
      rst_n = 1'b0;
      #1;
      model_ret = 0;
      chk("rst mem_read", 32'(mem_read_o), 32'd0);
      chk("rst ready2", 32'(instr_ready_o), 32'd0);
      chk("rst reg_write2", 32'(reg_write_o), 32'd0);
      chk("rst pc_en2", 32'(pc_en_o), 32'd0);
      chk("rst retired2", 32'(retired_o), model_ret);
      chk("rst rd", 32'(rd_o), 32'd0);
      mem_ack_i = 1'b1;
      step();
      chk("rst hold reg_write", 32'(reg_write_o), 32'd0);
      chk("rst hold pc_en", 32'(pc_en_o), 32'd0);
      mem_ack_i = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("ready before edge2", 32'(instr_ready_o), 32'd0);
      step();
      chk("ready after edge2", 32'(instr_ready_o), 32'd1);
      run_instr(32'h0070_0293, 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
